rom_loader_router: RTL and testbench
====================================

Name: rom_loader_router

Overview:
Parametrised successor to the board-level ROM download path. It takes the byte stream from data_io (ioctl_*) and routes each byte to one of NUM_PORTS SDRAM write ports using toggle req/ack handshakes and per-port region bases. It supports exclusive or broadcast routing, detects writes that arrive while a port is still busy, and generates rom_loaded and a stretched core reset. It sits between data_io and the sdram controller in every arcade top.

Parameters:
NUM_PORTS, 2, number of SDRAM write ports (1..4)
ADDR_W, 25, ioctl_addr width
REGION_BASE, {25'h20000,25'h0}, packed NUM_PORTS*ADDR_W; byte base of port i at slice i; must be ascending
BROADCAST, 1, 1 = write every port with addr>=base[i]; 0 = write only the highest i with addr>=base[i]
ROM_INDEX, 8'h00, ioctl_index value accepted as ROM data; other indices are ignored
RESET_HOLD, 255, clk_sys cycles core_reset stays high after download ends (0..65535)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  download target index
ioctl_wr  in  1  byte strobe (level; rising edge = new byte)
ioctl_addr  in  ADDR_W  byte address
ioctl_dout  in  8  byte data
user_reset  in  1  OSD/button reset request
port_ack  in  NUM_PORTS  per-port toggle ack from sdram
port_req  out  NUM_PORTS  per-port toggle request
port_a  out  ADDR_W-2  word address relative to the selected region (shared by all ports)
port_ds  out  2  byte strobes {addr[0], ~addr[0]}
port_d  out  16  {dout,dout}
port_we  out  1  equals ioctl_download
busy  out  1  handshake outstanding
overrun  out  1  sticky: a byte arrived while busy
rom_loaded  out  1  at least one complete download finished
core_reset  out  1  reset to game core

Behaviour:
- Reset values (reset_n=0 sampled): port_req=0, busy=0, overrun=0, rom_loaded=0, core_reset=1, hold counter=0, wr_last=0, FSM=IDLE. The sdram controller is reset with the same reset, so req==ack after reset.
- A byte is accepted on the clk_sys edge where ioctl_wr=1 & wr_last=0 & ioctl_download=1 & ioctl_index==ROM_INDEX.
- Port select mask: sel[i] = (addr>=base[i]). With BROADCAST=0, only the highest set bit is kept. If the mask is empty, the byte is dropped and the FSM stays IDLE.
- FSM IDLE: on an accepted byte, latch port_a=(addr-base[k])[ADDR_W-1:1], where k is the highest selected port (the same offset is presented to all selected ports). In the same edge, latch port_ds and port_d, toggle port_req[i] for each selected i, save the mask, and go to WAIT. req is visible one cycle after the first ioctl_wr high.
- FSM WAIT: busy=1. Return to IDLE on the edge where port_ack[i]==port_req[i] for every masked i. busy falls the next cycle.
- An accepted-condition edge while in WAIT sets overrun (sticky until reset_n). The byte is dropped and the FSM state is unchanged.
- port_a/ds/d hold their values until the next accepted byte.
- Download rising edge (ROM_INDEX): rom_loaded<=0, overrun<=0.
- Download falling edge: go to DRAIN.
  - DRAIN waits for the FSM to reach IDLE.
  - Then set rom_loaded<=1 and hold counter<=RESET_HOLD.
  - If a new download starts during DRAIN, it cancels the completion.
- core_reset = ~reset_n | user_reset | ~rom_loaded | ioctl_download | (counter!=0). The output is registered, i.e. 1-cycle latency. The counter decrements to 0 and saturates there.
- ioctl_addr below base[0] is dropped silently. Address subtraction is modulo 2^ADDR_W but is only used when addr>=base.
- If reset_n falls mid-handshake, state is abandoned; the controller is reset too.

Decomposition:
- Package rom_loader_pkg: fsm_t {IDLE, WAIT, DRAIN}, function region_sel(addr, bases, broadcast), and MAX_PORTS=4.
- One sub-module, reset_stretcher (counter + core_reset register), which is reusable by other tops.

Test Plan:
1. Reset, no download -> core_reset=1, rom_loaded=0, port_req=00.
2. BROADCAST=1, byte 0xA5 @ 0x20003 -> port_req=11, port_a=0x00001 (relative to 0x20000), ds=10, d=A5A5. Ack port0 only: busy stays 1. Ack port1: busy=0 two cycles later.
3. BROADCAST=0, byte @ 0x1FFFF -> only port_req[0] toggles, port_a=0xFFFF, ds=10. Byte @ 0x20000 -> only port_req[1] toggles, port_a=0, ds=01.
4. Second wr edge before ack -> overrun=1, port_req unchanged. Next download start -> overrun=0.
5. RESET_HOLD=4: download ends with ack pending. rom_loaded rises only after the ack. core_reset falls exactly 4 cycles (+1 register) later. Assert user_reset -> core_reset=1 the next cycle.
6. ioctl_index=1 bytes -> no req toggles. reset_n pulse mid-WAIT -> FSM IDLE, busy=0, rom_loaded=0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and the region-select helper for the ROM download router.
package rom_loader_pkg;

    localparam int unsigned MAX_PORTS  = 4;
    localparam int unsigned MAX_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fsm_t;

    // Ports whose base lies at or below addr; exclusive mode keeps only the highest one.
    function automatic logic [MAX_PORTS-1:0] region_sel(
        input logic [MAX_ADDR_W-1:0]           addr,
        input logic [MAX_PORTS*MAX_ADDR_W-1:0] bases,
        input int unsigned                     num_ports,
        input logic                            broadcast
    );
        logic [MAX_PORTS-1:0] sel;
        logic [MAX_PORTS-1:0] top;
        sel = '0;
        top = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < num_ports && addr >= bases[i*MAX_ADDR_W +: MAX_ADDR_W]) begin
                sel[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (sel[i]) begin
                top = MAX_PORTS'(1) << i;
            end
        end
        return broadcast ? sel : top;
    endfunction

endpackage

// File: rtl/reset_stretcher.sv
// Registered core reset: forced by i_force, then held HOLD cycles after each i_load pulse.
module reset_stretcher #(
    parameter int unsigned HOLD = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_force,
    output logic o_core_reset
);

    logic [15:0] r_cnt;
    logic        r_core_reset;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
        end else begin
            if (i_load) begin
                r_cnt <= 16'(HOLD);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            r_core_reset <= i_force | (r_cnt != '0);
        end
    end

    assign o_core_reset = r_core_reset;

endmodule

// File: rtl/rom_loader_router.sv
// Routes data_io ROM bytes to SDRAM write ports via toggle req/ack, and tracks
// download completion for rom_loaded and the stretched core reset.
module rom_loader_router
    import rom_loader_pkg::*;
#(
    parameter int unsigned                 NUM_PORTS   = 2,
    parameter int unsigned                 ADDR_W      = 25,
    parameter logic [NUM_PORTS*ADDR_W-1:0] REGION_BASE = {25'h20000, 25'h0},
    parameter bit                          BROADCAST   = 1'b1,
    parameter logic [7:0]                  ROM_INDEX   = 8'h00,
    parameter int unsigned                 RESET_HOLD  = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 user_reset,
    input  logic [NUM_PORTS-1:0] port_ack,
    output logic [NUM_PORTS-1:0] port_req,
    output logic [ADDR_W-3:0]    port_a,
    output logic [1:0]           port_ds,
    output logic [15:0]          port_d,
    output logic                 port_we,
    output logic                 busy,
    output logic                 overrun,
    output logic                 rom_loaded,
    output logic                 core_reset
);

    fsm_t                  r_state, w_next_state;
    logic                  r_wr_last, r_dl_last;
    logic [NUM_PORTS-1:0]  r_req, r_mask;
    logic [ADDR_W-3:0]     r_a;
    logic [1:0]            r_ds;
    logic [15:0]           r_d;
    logic                  r_busy, r_overrun, r_rom_loaded, r_drain;

    logic                  w_idx_ok, w_accept, w_dl_rise, w_dl_fall, w_acked;
    logic                  w_load, w_overrun_set, w_complete;
    logic [MAX_ADDR_W-1:0] w_addr_ext;
    logic [MAX_PORTS*MAX_ADDR_W-1:0] w_bases_ext;
    logic [MAX_PORTS-1:0]  w_sel_full;
    logic [NUM_PORTS-1:0]  w_sel;
    logic [ADDR_W-1:0]     w_base_k, w_diff;
    logic                  w_unused_diff;

    assign w_idx_ok  = (ioctl_index == ROM_INDEX);
    assign w_accept  = ioctl_wr & ~r_wr_last & ioctl_download & w_idx_ok;
    assign w_dl_rise = ioctl_download & ~r_dl_last & w_idx_ok;
    assign w_dl_fall = ~ioctl_download & r_dl_last & w_idx_ok;
    assign w_acked   = ((port_ack ^ r_req) & r_mask) == '0;

    assign w_addr_ext = MAX_ADDR_W'(ioctl_addr);

    always_comb begin
        w_bases_ext = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_bases_ext[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(REGION_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    assign w_sel_full = region_sel(w_addr_ext, w_bases_ext, NUM_PORTS, BROADCAST);
    assign w_sel      = w_sel_full[NUM_PORTS-1:0];

    if (NUM_PORTS < MAX_PORTS) begin : g_sel_pad
        logic w_unused_sel;
        assign w_unused_sel = |w_sel_full[MAX_PORTS-1:NUM_PORTS];
    end

    // Offset is always taken against the highest selected region, even in broadcast mode.
    always_comb begin
        w_base_k = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_sel[i]) begin
                w_base_k = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_diff        = ioctl_addr - w_base_k;
    assign w_unused_diff = w_diff[ADDR_W-1] ^ w_diff[0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_sel != '0)) begin
                    w_load       = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_overrun_set = w_accept;
                if (w_acked) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wr_last <= 1'b0;
            r_dl_last <= 1'b0;
            r_req     <= '0;
            r_mask    <= '0;
            r_a       <= '0;
            r_ds      <= '0;
            r_d       <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_last <= ioctl_wr;
            r_dl_last <= ioctl_download;
            r_busy    <= (r_state == WAIT);
            if (w_load) begin
                r_req  <= r_req ^ w_sel;
                r_mask <= w_sel;
                r_a    <= w_diff[ADDR_W-2:1];
                r_ds   <= {ioctl_addr[0], ~ioctl_addr[0]};
                r_d    <= {ioctl_dout, ioctl_dout};
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_dl_rise) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Completion is deferred until the last handshake has drained; a restart cancels it.
    assign w_complete = r_drain & (r_state == IDLE) & ~w_dl_rise & ~w_dl_fall;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_rom_loaded <= 1'b0;
            r_drain      <= 1'b0;
        end else if (w_dl_rise) begin
            r_rom_loaded <= 1'b0;
            r_drain      <= 1'b0;
        end else if (w_dl_fall) begin
            r_drain      <= 1'b1;
        end else if (w_complete) begin
            r_rom_loaded <= 1'b1;
            r_drain      <= 1'b0;
        end
    end

    reset_stretcher #(
        .HOLD (RESET_HOLD)
    ) u_reset_stretcher (
        .clk          (clk_sys),
        .reset_n      (reset_n),
        .i_load       (w_complete),
        .i_force      (user_reset | ~r_rom_loaded | ioctl_download),
        .o_core_reset (core_reset)
    );

    assign port_req   = r_req;
    assign port_a     = r_a;
    assign port_ds    = r_ds;
    assign port_d     = r_d;
    assign port_we    = ioctl_download;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign rom_loaded = r_rom_loaded;

endmodule

// File: tb/tb_rom_loader_router.sv
// Directed bench: one broadcast and one exclusive router driven by the same byte stream.
module tb_rom_loader_router;

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n, ioctl_download, ioctl_wr, user_reset;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic [1:0]  ack_bc, ack_ex, req_bc, req_ex;
    logic [22:0] a_bc, a_ex;
    logic [1:0]  ds_bc, ds_ex;
    logic [15:0] d_bc, d_ex;
    logic        we_bc, we_ex, busy_bc, busy_ex, ovr_bc, ovr_ex, ld_bc, ld_ex, cr_bc, cr_ex;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_bc, exp_ex;

    rom_loader_router #(
        .NUM_PORTS(2), .ADDR_W(25), .REGION_BASE({25'h20000, 25'h0}),
        .BROADCAST(1'b1), .ROM_INDEX(8'h00), .RESET_HOLD(4)
    ) u_bc (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .port_ack(ack_bc),
        .port_req(req_bc), .port_a(a_bc), .port_ds(ds_bc), .port_d(d_bc),
        .port_we(we_bc), .busy(busy_bc), .overrun(ovr_bc), .rom_loaded(ld_bc),
        .core_reset(cr_bc)
    );

    rom_loader_router #(
        .NUM_PORTS(2), .ADDR_W(25), .REGION_BASE({25'h20000, 25'h0}),
        .BROADCAST(1'b0), .ROM_INDEX(8'h00), .RESET_HOLD(4)
    ) u_ex (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .port_ack(ack_ex),
        .port_req(req_ex), .port_a(a_ex), .port_ds(ds_ex), .port_d(d_ex),
        .port_we(we_ex), .busy(busy_ex), .overrun(ovr_ex), .rom_loaded(ld_ex),
        .core_reset(cr_ex)
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  d;
        logic [1:0]  tog_bc;
        logic [1:0]  tog_ex;
        logic [22:0] a;
        logic [1:0]  ds;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_pulse(input logic [24:0] addr, input logic [7:0] d);
        ioctl_addr = addr;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_all();
        ack_bc = exp_bc;
        ack_ex = exp_ex;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{25'h0020003, 8'hA5, 2'b11, 2'b10, 23'h000001, 2'b10};
        vecs[1] = '{25'h001FFFF, 8'h3C, 2'b01, 2'b01, 23'h00FFFF, 2'b10};
        vecs[2] = '{25'h0020000, 8'h5A, 2'b11, 2'b10, 23'h000000, 2'b01};
        vecs[3] = '{25'h0000000, 8'h11, 2'b01, 2'b01, 23'h000000, 2'b01};
        vecs[4] = '{25'h0000002, 8'h22, 2'b01, 2'b01, 23'h000001, 2'b01};
        vecs[5] = '{25'h001FFFE, 8'h33, 2'b01, 2'b01, 23'h00FFFF, 2'b01};
        vecs[6] = '{25'h003FFFF, 8'h77, 2'b11, 2'b10, 23'h00FFFF, 2'b10};
        vecs[7] = '{25'h1FFFFFF, 8'hFF, 2'b11, 2'b10, 23'h7EFFFF, 2'b10};

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; user_reset = 1'b0;
        ioctl_index = 8'h00; ioctl_dout = 8'h00; ioctl_addr = '0;
        ack_bc = 2'b00; ack_ex = 2'b00; exp_bc = 2'b00; exp_ex = 2'b00;

        // Reset state
        repeat (3) tick();
        chk("rst core_reset", 32'(cr_bc), 32'd1);
        chk("rst rom_loaded", 32'(ld_bc), 32'd0);
        chk("rst req_bc", 32'(req_bc), 32'd0);
        chk("rst req_ex", 32'(req_ex), 32'd0);
        chk("rst busy", 32'(busy_bc), 32'd0);
        chk("rst overrun", 32'(ovr_bc), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk("idle core_reset", 32'(cr_ex), 32'd1);

        ioctl_download = 1'b1;
        repeat (2) tick();
        chk("we during download", 32'(we_bc & we_ex), 32'd1);

        // Table: one byte each, full ack
        for (int i = 0; i < 8; i++) begin
            wr_pulse(vecs[i].addr, vecs[i].d);
            exp_bc ^= vecs[i].tog_bc;
            exp_ex ^= vecs[i].tog_ex;
            chk($sformatf("v%0d req_bc", i), 32'(req_bc), 32'(exp_bc));
            chk($sformatf("v%0d req_ex", i), 32'(req_ex), 32'(exp_ex));
            chk($sformatf("v%0d a_bc", i), 32'(a_bc), 32'(vecs[i].a));
            chk($sformatf("v%0d a_ex", i), 32'(a_ex), 32'(vecs[i].a));
            chk($sformatf("v%0d ds", i), 32'({ds_bc, ds_ex}), 32'({vecs[i].ds, vecs[i].ds}));
            chk($sformatf("v%0d d", i), 32'({d_bc, d_ex}), {vecs[i].d, vecs[i].d, vecs[i].d, vecs[i].d});
            tick();
            chk($sformatf("v%0d busy set", i), 32'({busy_bc, busy_ex}), 32'b11);
            ack_all();
            tick();
            tick();
            chk($sformatf("v%0d busy clr", i), 32'({busy_bc, busy_ex}), 32'b00);
            chk($sformatf("v%0d overrun", i), 32'({ovr_bc, ovr_ex}), 32'b00);
        end

        // Partial ack keeps the broadcast router busy
        wr_pulse(25'h0020003, 8'hA5);
        exp_bc ^= 2'b11;
        exp_ex ^= 2'b10;
        tick();
        ack_bc[0] = exp_bc[0];
        ack_ex = exp_ex;
        repeat (3) tick();
        chk("partial ack busy", 32'(busy_bc), 32'd1);
        chk("exclusive done", 32'(busy_ex), 32'd0);
        ack_bc[1] = exp_bc[1];
        tick();
        chk("ack+1 busy", 32'(busy_bc), 32'd1);
        tick();
        chk("ack+2 busy", 32'(busy_bc), 32'd0);

        // Overrun: second strobe before ack
        wr_pulse(25'h0000040, 8'h11);
        exp_bc ^= 2'b01;
        exp_ex ^= 2'b01;
        tick();
        wr_pulse(25'h0000042, 8'h22);
        chk("overrun set", 32'({ovr_bc, ovr_ex}), 32'b11);
        chk("overrun req_bc", 32'(req_bc), 32'(exp_bc));
        chk("overrun req_ex", 32'(req_ex), 32'(exp_ex));
        chk("overrun a held", 32'(a_bc), 32'h20);
        tick();
        ack_all();
        repeat (2) tick();
        chk("overrun sticky", 32'(ovr_bc), 32'd1);
        ioctl_download = 1'b0;
        n = 0;
        while (!ld_bc && n < 20) begin tick(); n++; end
        chk("loaded after ovr dl", 32'(ld_bc), 32'd1);
        ioctl_download = 1'b1;
        tick();
        chk("overrun cleared", 32'({ovr_bc, ovr_ex}), 32'b00);
        chk("loaded cleared", 32'(ld_bc), 32'd0);

        // Download ends with ack pending
        tick();
        wr_pulse(25'h0000100, 8'h33);
        exp_bc ^= 2'b01;
        exp_ex ^= 2'b01;
        tick();
        ioctl_download = 1'b0;
        repeat (6) tick();
        chk("drain not loaded", 32'({ld_bc, ld_ex}), 32'b00);
        chk("drain core_reset", 32'(cr_bc), 32'd1);
        ack_all();
        n = 0;
        while (!ld_bc && n < 20) begin tick(); n++; end
        chk("drain loaded", 32'(ld_bc), 32'd1);
        n = 0;
        while (cr_bc && n < 20) begin tick(); n++; end
        chk("hold cycles", 32'(n), 32'd5);
        chk("ex core_reset low", 32'(cr_ex), 32'd0);
        chk("ex loaded", 32'(ld_ex), 32'd1);
        user_reset = 1'b1;
        tick();
        chk("user_reset", 32'(cr_bc), 32'd1);
        user_reset = 1'b0;
        tick();
        chk("user_reset release", 32'(cr_bc), 32'd0);

        // Foreign index: ignored
        ioctl_index = 8'h01;
        ioctl_download = 1'b1;
        tick();
        chk("idx1 loaded kept", 32'(ld_bc), 32'd1);
        chk("idx1 core_reset", 32'(cr_bc), 32'd1);
        wr_pulse(25'h0020003, 8'h44);
        tick();
        chk("idx1 req_bc", 32'(req_bc), 32'(exp_bc));
        chk("idx1 req_ex", 32'(req_ex), 32'(exp_ex));
        chk("idx1 busy", 32'(busy_bc), 32'd0);
        ioctl_download = 1'b0;
        tick();
        ioctl_index = 8'h00;
        tick();
        chk("idx1 end core_reset", 32'(cr_bc), 32'd0);

        // Reset pulse mid-handshake
        ioctl_download = 1'b1;
        tick();
        wr_pulse(25'h0000020, 8'h55);
        tick();
        chk("pre-reset busy", 32'(busy_bc), 32'd1);
        reset_n = 1'b0;
        ack_bc = 2'b00;
        ack_ex = 2'b00;
        exp_bc = 2'b00;
        exp_ex = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post-reset busy", 32'({busy_bc, busy_ex}), 32'b00);
        chk("post-reset loaded", 32'(ld_bc), 32'd0);
        chk("post-reset req", 32'({req_bc, req_ex}), 32'd0);
        wr_pulse(25'h0020003, 8'h66);
        exp_bc ^= 2'b11;
        exp_ex ^= 2'b10;
        chk("post-reset accept bc", 32'(req_bc), 32'(exp_bc));
        chk("post-reset accept ex", 32'(req_ex), 32'(exp_ex));
        chk("post-reset no overrun", 32'(ovr_bc), 32'd0);
        tick();
        chk("post-reset busy again", 32'(busy_bc), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
